audio_in: RTL and testbench

AUDIO_IN -- requirements
Module: audio_in

---
 rtl/audio_pkg.sv | 25 ++
 rtl/audio_in_if.sv | 28 ++
 rtl/audio_iis_clkgen.sv | 44 ++++
 rtl/audio_in.sv | 103 ++++++++++
 tb/tb_audio_in.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared constants, types and helpers for the I2S ADC capture block.
// Frame timing is expressed as positions of the free-running 256-count MCLK divider.
package audio_pkg;

  localparam int DEF_MCLK_LRCK_RATIO = 256;
  localparam int DEF_SCLK_LRCK_RATIO = 64;
  localparam int DEF_DATA_WIDTH      = 24;

  // I2S puts the MSB one SCLK after the LRCK edge, so slot 0 is skipped.
  localparam int SLOT_FIRST      = 1;
  localparam int SLOT_LAST       = 24;
  localparam int CAPTURE_PHASE   = 3;
  localparam int LATCH_LEFT_CNT  = 99;
  localparam int LATCH_RIGHT_CNT = 227;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  function automatic logic slot_captured(input int slot);
    return (slot >= SLOT_FIRST) && (slot <= SLOT_LAST);
  endfunction

endpackage

// File: rtl/audio_in_if.sv
// Timing bus from the I2S clock generator to the capture/handshake logic.
// The clock generator drives every signal; the capture side only listens.
interface audio_in_if;
  import audio_pkg::*;

  logic     sclk;
  channel_e lrck;
  logic     capture;
  logic     latch_left;
  logic     latch_right;

  modport master (
    output sclk,
    output lrck,
    output capture,
    output latch_left,
    output latch_right
  );

  modport slave (
    input sclk,
    input lrck,
    input capture,
    input latch_left,
    input latch_right
  );

endinterface

// File: rtl/audio_iis_clkgen.sv
// Free-running MCLK divider producing SCLK/LRCK and the capture/latch strobes.
// SCLK and LRCK are plain divider flop bits, so they cannot glitch.
module audio_iis_clkgen
  import audio_pkg::*;
#(
  parameter int MCLK_LRCK_RATIO = DEF_MCLK_LRCK_RATIO,
  parameter int SCLK_LRCK_RATIO = DEF_SCLK_LRCK_RATIO
) (
  input  logic       clk_i,
  input  logic       rst_i,
  audio_in_if.master tim
);

  localparam int DIV_W    = $clog2(MCLK_LRCK_RATIO);
  localparam int SCLK_BIT = $clog2(MCLK_LRCK_RATIO / SCLK_LRCK_RATIO) - 1;

  localparam logic [SCLK_BIT:0] CAP_PHASE = CAPTURE_PHASE[SCLK_BIT:0];
  localparam logic [DIV_W-1:0]  LATCH_L   = LATCH_LEFT_CNT[DIV_W-1:0];
  localparam logic [DIV_W-1:0]  LATCH_R   = LATCH_RIGHT_CNT[DIV_W-1:0];

  logic [DIV_W-1:0]          div_cnt_q;
  logic [DIV_W-1:0]          div_cnt_d;
  logic [DIV_W-SCLK_BIT-3:0] slot;

  assign div_cnt_d = div_cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Slot index within the current half-frame; the top bit selects the channel.
  assign slot = div_cnt_q[DIV_W-2:SCLK_BIT+1];

  assign tim.sclk        = div_cnt_q[SCLK_BIT];
  assign tim.lrck        = channel_e'(div_cnt_q[DIV_W-1]);
  assign tim.capture     = (div_cnt_q[SCLK_BIT:0] == CAP_PHASE) && slot_captured(int'(slot));
  assign tim.latch_left  = (div_cnt_q == LATCH_L);
  assign tim.latch_right = (div_cnt_q == LATCH_R);

endmodule

// File: rtl/audio_in.sv
// I2S master receiver: generates MCLK/SCLK/LRCK for an ADC, deserialises both
// channels and offers each stereo pair on a valid/ready output with overflow flag.
module audio_in
  import audio_pkg::*;
#(
  parameter int OUT_MCLK_LRCK_RATIO = DEF_MCLK_LRCK_RATIO,
  parameter int OUT_SCLK_LRCK_RATIO = DEF_SCLK_LRCK_RATIO,
  parameter int DATA_WIDTH          = DEF_DATA_WIDTH
) (
  input  logic                  CLK_12288KHZ_I,
  input  logic                  RST_I,
  input  logic                  IIS_SDIN_I,
  input  logic                  LEFT_ENABLE_I,
  input  logic                  RIGHT_ENABLE_I,
  input  logic                  READY_I,
  output logic                  IIS_MCLK_O,
  output logic                  IIS_SCLK_O,
  output logic                  IIS_LRCK_O,
  output logic [DATA_WIDTH-1:0] LEFT_DATA_O,
  output logic [DATA_WIDTH-1:0] RIGHT_DATA_O,
  output logic                  VALID_O,
  output logic                  OVERFLOW_O
);

  audio_in_if tim ();

  audio_iis_clkgen #(
    .MCLK_LRCK_RATIO (OUT_MCLK_LRCK_RATIO),
    .SCLK_LRCK_RATIO (OUT_SCLK_LRCK_RATIO)
  ) u_clkgen (
    .clk_i (CLK_12288KHZ_I),
    .rst_i (RST_I),
    .tim   (tim)
  );

  logic                  sdin_q;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic [DATA_WIDTH-1:0] hold_q,     hold_d;
  logic [DATA_WIDTH-1:0] left_q,     left_d;
  logic [DATA_WIDTH-1:0] right_q,    right_d;
  logic                  valid_q,    valid_d;
  logic                  overflow_q, overflow_d;

  // Output handshake: a pair transfers on any edge where VALID_O and READY_I
  // are both high; data holds while VALID_O=1 and READY_I=0. A new pair
  // always loads; if the old one was still pending and not being taken on
  // that edge, OVERFLOW_O pulses for one cycle.
  always_comb begin
    shift_d    = shift_q;
    hold_d     = hold_q;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;

    if (tim.capture) begin
      shift_d = {shift_q[DATA_WIDTH-2:0], sdin_q};
    end

    // The last data bit lands on the same edge as the latch, so use shift_d.
    if (tim.latch_left) begin
      hold_d = LEFT_ENABLE_I ? shift_d : '0;
    end

    if (tim.latch_right) begin
      left_d     = hold_q;
      right_d    = RIGHT_ENABLE_I ? shift_d : '0;
      valid_d    = 1'b1;
      overflow_d = valid_q && !READY_I;
    end else if (valid_q && READY_I) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_12288KHZ_I) begin
    if (RST_I) begin
      sdin_q     <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sdin_q     <= IIS_SDIN_I;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign IIS_MCLK_O   = CLK_12288KHZ_I;
  assign IIS_SCLK_O   = tim.sclk;
  assign IIS_LRCK_O   = tim.lrck;
  assign LEFT_DATA_O  = left_q;
  assign RIGHT_DATA_O = right_q;
  assign VALID_O      = valid_q;
  assign OVERFLOW_O   = overflow_q;

endmodule

// File: tb/tb_audio_in.sv
// Directed bench for audio_in: an I2S ADC model slaved to the DUT's SCLK/LRCK,
// a vector table for the data path and hand-written handshake/reset sequences.
module tb_audio_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdin = 1'b0;
  logic        left_en = 1'b1;
  logic        right_en = 1'b1;
  logic        ready = 1'b1;
  logic        iis_mclk;
  logic        iis_sclk;
  logic        iis_lrck;
  logic [23:0] left_data;
  logic [23:0] right_data;
  logic        valid;
  logic        overflow;

  logic [23:0] adc_left = '0;
  logic [23:0] adc_right = '0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [23:0] left_in;
    logic [23:0] right_in;
    logic        left_en;
    logic        right_en;
    logic [23:0] exp_left;
    logic [23:0] exp_right;
  } vec_t;

  vec_t vecs[6];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  audio_in dut (
    .CLK_12288KHZ_I (clk),
    .RST_I          (rst),
    .IIS_SDIN_I     (sdin),
    .LEFT_ENABLE_I  (left_en),
    .RIGHT_ENABLE_I (right_en),
    .READY_I        (ready),
    .IIS_MCLK_O     (iis_mclk),
    .IIS_SCLK_O     (iis_sclk),
    .IIS_LRCK_O     (iis_lrck),
    .LEFT_DATA_O    (left_data),
    .RIGHT_DATA_O   (right_data),
    .VALID_O        (valid),
    .OVERFLOW_O     (overflow)
  );

  // ---------------- ADC model ----------------
  // Shifts a new bit out after each SCLK fall; the fall coinciding with an
  // LRCK change is slot 0, MSB goes out in slot 1, LSB in slot 24.
  int          adc_slot = 0;
  logic        adc_prev_sclk = 1'b0;
  logic        adc_prev_lrck = 1'b0;
  logic [23:0] adc_word;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      adc_slot      = 0;
      adc_prev_sclk = 1'b0;
      adc_prev_lrck = 1'b0;
      sdin          = 1'b0;
    end else begin
      if (adc_prev_sclk && !iis_sclk) begin
        if (iis_lrck != adc_prev_lrck) adc_slot = 0;
        else adc_slot++;
        adc_prev_lrck = iis_lrck;
        adc_word = iis_lrck ? adc_right : adc_left;
        sdin = (adc_slot >= 1 && adc_slot <= 24) ? adc_word[24 - adc_slot] : 1'b0;
      end
      adc_prev_sclk = iis_sclk;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for VALID_O at a falling edge; returns cycles waited.
  task automatic wait_pair(output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 600) begin
      @(negedge clk);
      cycles++;
      seen = valid;
    end
    check("pair_seen", {31'b0, seen}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int   n;
    logic ok;
    int   first_valid, sclk_r1, sclk_r2, lrck_rise, lrck_fall;
    int   ovf_cnt, ovf_first, vlow;
    logic prev_s, prev_l;

    vecs[0] = '{24'h800001, 24'h7FFFFF, 1'b1, 1'b1, 24'h800001, 24'h7FFFFF};
    vecs[1] = '{24'h123456, 24'hABCDEF, 1'b0, 1'b1, 24'h000000, 24'hABCDEF};
    vecs[2] = '{24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b0, 24'hA5A5A5, 24'h000000};
    vecs[3] = '{24'hFFFFFF, 24'h000000, 1'b1, 1'b1, 24'hFFFFFF, 24'h000000};
    vecs[4] = '{24'h000001, 24'h800000, 1'b1, 1'b1, 24'h000001, 24'h800000};
    vecs[5] = '{24'h3C3C3C, 24'hC3C3C3, 1'b0, 1'b0, 24'h000000, 24'h000000};

    // Reset state and clock timing after release.
    adc_left  = 24'h800001;
    adc_right = 24'h7FFFFF;
    repeat (3) @(negedge clk);
    check("rst_sclk", {31'b0, iis_sclk}, 32'd0);
    check("rst_lrck", {31'b0, iis_lrck}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_left", {8'b0, left_data}, 32'd0);
    check("rst_right", {8'b0, right_data}, 32'd0);

    rst = 1'b0;
    first_valid = 0; sclk_r1 = 0; sclk_r2 = 0; lrck_rise = 0; lrck_fall = 0;
    prev_s = iis_sclk;
    prev_l = iis_lrck;
    for (int cyc = 1; cyc <= 260; cyc++) begin
      @(negedge clk);
      if (!prev_s && iis_sclk) begin
        if (sclk_r1 == 0) sclk_r1 = cyc;
        else if (sclk_r2 == 0) sclk_r2 = cyc;
      end
      if (!prev_l && iis_lrck && lrck_rise == 0) lrck_rise = cyc;
      if (prev_l && !iis_lrck && lrck_fall == 0) lrck_fall = cyc;
      if (valid && first_valid == 0) begin
        first_valid = cyc;
        check("first_left", {8'b0, left_data}, 32'h800001);
        check("first_right", {8'b0, right_data}, 32'h7FFFFF);
      end
      prev_s = iis_sclk;
      prev_l = iis_lrck;
    end
    check("sclk_first_rise", sclk_r1, 32'd2);
    check("sclk_period", sclk_r2 - sclk_r1, 32'd4);
    check("lrck_rise", lrck_rise, 32'd128);
    check("lrck_fall", lrck_fall, 32'd256);
    check("first_valid_clock", first_valid, 32'd228);

    // Data path vectors with READY_I held high.
    wait_pair(n);
    @(negedge clk);
    check("valid_one_cycle", {31'b0, valid}, 32'd0);
    for (int v = 0; v < 6; v++) begin
      adc_left  = vecs[v].left_in;
      adc_right = vecs[v].right_in;
      left_en   = vecs[v].left_en;
      right_en  = vecs[v].right_en;
      wait_pair(n);
      // Started one cycle after the previous pair, so 255 cycles to the next.
      check("vec_period", n, 32'd255);
      check("vec_left", {8'b0, left_data}, {8'b0, vecs[v].exp_left});
      check("vec_right", {8'b0, right_data}, {8'b0, vecs[v].exp_right});
      @(negedge clk);
      check("vec_valid_drop", {31'b0, valid}, 32'd0);
    end
    left_en  = 1'b1;
    right_en = 1'b1;

    // Consumer stalled for 600 clocks: two overwrites, data tracks newest pair.
    ready     = 1'b0;
    adc_left  = 24'h111111;
    adc_right = 24'h222222;
    wait_pair(n);
    adc_left  = 24'h333333;
    adc_right = 24'h444444;
    ovf_cnt = 0; ovf_first = 0; vlow = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (!valid) vlow++;
      if (overflow) begin
        ovf_cnt++;
        if (ovf_first == 0) begin
          ovf_first = i;
          adc_left  = 24'h555555;
          adc_right = 24'h666666;
        end
      end
      if (i == 100) begin
        check("stall_hold_left", {8'b0, left_data}, 32'h111111);
        check("stall_hold_right", {8'b0, right_data}, 32'h222222);
      end
      if (i == 300) begin
        check("stall_new_left", {8'b0, left_data}, 32'h333333);
        check("stall_new_right", {8'b0, right_data}, 32'h444444);
      end
    end
    check("overflow_pulses", ovf_cnt, 32'd2);
    check("overflow_first", ovf_first, 32'd256);
    check("stall_valid_low_cycles", vlow, 32'd0);
    check("stall_last_left", {8'b0, left_data}, 32'h555555);
    check("stall_last_right", {8'b0, right_data}, 32'h666666);

    // READY_I rises exactly on the edge a new pair lands.
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (overflow) begin
        ok = 1'b1;
        break;
      end
    end
    check("sync_ovf_seen", {31'b0, ok}, 32'd1);
    adc_left  = 24'hC0FFEE;
    adc_right = 24'h0BEEF0;
    repeat (255) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    check("sync_valid", {31'b0, valid}, 32'd1);
    check("sync_left", {8'b0, left_data}, 32'hC0FFEE);
    check("sync_right", {8'b0, right_data}, 32'h0BEEF0);
    check("sync_no_overflow", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    check("sync_drain", {31'b0, valid}, 32'd0);

    // Reset pulsed mid-frame at divider count 150.
    wait_pair(n);
    adc_left  = 24'h654321;
    adc_right = 24'h9ABCDE;
    repeat (178) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_left", {8'b0, left_data}, 32'd0);
    check("mid_rst_right", {8'b0, right_data}, 32'd0);
    check("mid_rst_sclk", {31'b0, iis_sclk}, 32'd0);
    check("mid_rst_lrck", {31'b0, iis_lrck}, 32'd0);
    rst = 1'b0;
    first_valid = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (valid && first_valid == 0) begin
        first_valid = cyc;
        check("mid_rst_pair_left", {8'b0, left_data}, 32'h654321);
        check("mid_rst_pair_right", {8'b0, right_data}, 32'h9ABCDE);
      end
    end
    check("mid_rst_first_valid", first_valid, 32'd228);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
